// File: rtl/uart_ram_tx_ctrl.sv
// Streams a burst of RAM bytes to a UART transmitter, one byte per tx_end handshake.
// Latency: start -> ram_rd_en 1 cycle, -> tx_int 3 cycles; tx_end rise -> next tx_int 4 cycles.
// Backpressure: each byte waits in SEND for a tx_end rising edge; abort cancels the burst.
module uart_ram_tx_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_int,
    input  logic              tx_end,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, LOAD, SEND, NEXT, FIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic              tx_end_q;
    logic              tx_end_rise;
    logic              abort_hit;

    assign tx_end_rise = tx_end && !tx_end_q;
    assign abort_hit   = abort && (state != IDLE) && (state != FIN);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_nxt  = start_addr;
                        cnt_nxt   = len;
                        state_nxt = RD;
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            RD:   state_nxt = WAIT;
            WAIT: state_nxt = LOAD;
            LOAD: state_nxt = SEND;
            SEND: begin
                if (tx_end_rise) state_nxt = NEXT;
            end
            NEXT: begin
                cnt_nxt   = cnt - 1'b1;
                addr_nxt  = addr + 1'b1;
                state_nxt = (cnt_nxt == '0) ? FIN : RD;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Cancellation overrides every transition, including the final NEXT -> FIN.
        if (abort_hit) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            cnt       <= '0;
            tx_end_q  <= 1'b0;
            ram_rd_en <= 1'b0;
            ram_addr  <= '0;
            tx_data   <= '0;
            tx_int    <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            cnt       <= cnt_nxt;
            tx_end_q  <= tx_end;
            // Outputs are decoded from the next state so they line up with the state they belong to.
            ram_rd_en <= (state_nxt == RD);
            if (state_nxt == RD) ram_addr <= addr_nxt;
            if ((state == WAIT) && (state_nxt == LOAD)) tx_data <= ram_rd_data;
            tx_int    <= (state_nxt == LOAD);
            done      <= (state_nxt == FIN);
            aborted   <= abort_hit;
        end
    end

endmodule

// File: tb/tb_uart_ram_tx_ctrl.sv
// Randomized bench for uart_ram_tx_ctrl: a RAM model, a UART responder and a burst-level reference.
module tb_uart_ram_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] len;
    logic       abort;
    logic       ram_rd_en;
    logic [7:0] ram_addr;
    logic [7:0] ram_rd_data;
    logic [7:0] tx_data;
    logic       tx_int;
    logic       tx_end;
    logic       busy;
    logic       done;
    logic       aborted;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [256];
    bit         rd_pend = 1'b0;
    logic [7:0] rd_pend_addr = 8'h00;

    uart_ram_tx_ctrl #(.ADDR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .len         (len),
        .abort       (abort),
        .ram_rd_en   (ram_rd_en),
        .ram_addr    (ram_addr),
        .ram_rd_data (ram_rd_data),
        .tx_data     (tx_data),
        .tx_int      (tx_int),
        .tx_end      (tx_end),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    always #10 clk = ~clk;

    // Synchronous-read RAM: data is only meaningful in the cycle after the read strobe.
    always @(negedge clk) begin
        ram_rd_data  = rd_pend ? mem[rd_pend_addr] : 8'($urandom);
        rd_pend      = ram_rd_en;
        rd_pend_addr = ram_addr;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ram_rd_en"}, ram_rd_en, 0);
        check({pfx, "_ram_addr"},  ram_addr,  0);
        check({pfx, "_tx_data"},   tx_data,   0);
        check({pfx, "_tx_int"},    tx_int,    0);
        check({pfx, "_busy"},      busy,      0);
        check({pfx, "_done"},      done,      0);
        check({pfx, "_aborted"},   aborted,   0);
    endtask

    // One burst: drive start, play the UART side, record what the DUT does, then compare
    // against the burst the rules describe (addresses sa+i mod 256, bytes mem[...], timing).
    task automatic run_burst(input logic [7:0] sa, input int ln, input int abort_byte,
                             input bit hold, input bit abort_idle, input bit start_mid,
                             input int dly);
        int rel, budget, d, rise_at, fall_at, low_at, abort_at, mid_at;
        int exp_tx_rel, exp_done_rel, n_rd, n_tx, n_done, n_abt, done_rel, abt_rel, end_rel, exp_n;
        bit exp_abt;
        logic [7:0] q_addr [$];
        logic [7:0] q_dat [$];
        logic [7:0] a;
        rise_at = -1; fall_at = -1; low_at = -1; abort_at = -1; mid_at = -1;
        exp_tx_rel = 2; exp_done_rel = 0;
        n_rd = 0; n_tx = 0; n_done = 0; n_abt = 0;
        done_rel = -1; abt_rel = -1; end_rel = -1;
        budget = 40 + ln * 32;

        start = 1'b1; start_addr = sa; len = 9'(ln); abort = abort_idle; tx_end = hold;
        @(negedge clk);
        rel = 0;
        start = 1'b0; start_addr = 8'($urandom); len = 9'($urandom_range(0, 511));

        while (rel <= budget) begin
            if (ram_rd_en) begin
                if (n_rd == 0) check("first_rd_rel", rel, 0);
                q_addr.push_back(ram_addr);
                n_rd++;
            end
            if (tx_int) begin
                check("tx_int_rel", rel, exp_tx_rel);
                q_dat.push_back(tx_data);
                n_tx++;
                d = (dly != 0) ? dly : $urandom_range(4, 20);
                rise_at = rel + d;
                low_at  = hold ? rel + d - 2 : -1;
                fall_at = hold ? -1 : rise_at + $urandom_range(1, 3);
                if (n_tx == abort_byte) abort_at = rel + 1 + $urandom_range(0, 2);
                if (start_mid && n_tx == 1) mid_at = rel + 1;
            end
            if (done)    begin n_done++; done_rel = rel; end
            if (aborted) begin n_abt++;  abt_rel  = rel; end
            if (end_rel < 0 && (done || aborted)) end_rel = rel;
            if (end_rel >= 0 && rel >= end_rel + 3) break;

            abort = (rel == abort_at) || (abort_idle && ln == 0 && rel == 0);
            start = (rel == mid_at);
            if (rel == low_at) tx_end = 1'b0;
            if (rel == rise_at) begin
                tx_end       = 1'b1;
                exp_tx_rel   = rel + 4;
                exp_done_rel = rel + 2;
            end
            if (rel == fall_at) tx_end = 1'b0;
            @(negedge clk);
            rel++;
        end

        if (end_rel < 0) check("burst_end_seen", 0, 1);
        exp_abt = (abort_byte > 0) && (abort_byte <= ln);
        exp_n   = exp_abt ? abort_byte : ln;
        check("n_rd", n_rd, exp_n);
        check("n_tx", n_tx, exp_n);
        for (int i = 0; i < exp_n && i < q_addr.size(); i++) begin
            a = sa + 8'(i);
            check("rd_addr", q_addr[i], a);
        end
        for (int i = 0; i < exp_n && i < q_dat.size(); i++) begin
            a = sa + 8'(i);
            check("tx_byte", q_dat[i], mem[a]);
        end
        check("done_cnt",  n_done, exp_abt ? 0 : 1);
        check("abort_cnt", n_abt,  exp_abt ? 1 : 0);
        if (exp_abt) check("abort_rel", abt_rel, abort_at + 1);
        else         check("done_rel", done_rel, (ln == 0) ? 0 : exp_done_rel);
        check("busy_after", busy, 0);
        if (exp_n > 0) begin
            a = sa + 8'(exp_n - 1);
            check("tx_data_hold", tx_data, mem[a]);
        end
        start = 1'b0; abort = 1'b0; tx_end = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_mid_burst();
        int noisy;
        noisy = 0;
        mem[8'h33] = 8'hA5;
        start = 1'b1; start_addr = 8'h33; len = 9'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_tx_int", tx_int, 1);
        check("pre_rst_tx_data", tx_data, 8'hA5);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        tx_end = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (busy || done || aborted || ram_rd_en || tx_int) noisy++;
        end
        check("post_rst_quiet", noisy, 0);
        tx_end = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int ln, ab;
        rst_n = 1'b0; start = 1'b0; start_addr = 8'h00; len = 9'd0; abort = 1'b0; tx_end = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        mem[8'h10] = 8'h41; mem[8'h11] = 8'h42; mem[8'h12] = 8'h43;
        run_burst(8'h10, 3, 0, 1'b0, 1'b0, 1'b0, 20);
        run_burst(8'h00, 0, 0, 1'b0, 1'b1, 1'b0, 0);
        run_burst(8'hFE, 4, 0, 1'b0, 1'b0, 1'b0, 0);
        run_burst(8'h20, 5, 2, 1'b0, 1'b0, 1'b0, 0);
        run_burst(8'h20, 5, 0, 1'b0, 1'b0, 1'b0, 0);
        run_burst(8'h40, 4, 0, 1'b1, 1'b0, 1'b1, 0);
        reset_mid_burst();
        run_burst(8'h33, 2, 0, 1'b0, 1'b0, 1'b0, 0);
        run_burst(8'($urandom), 256, 0, 1'b0, 1'b0, 1'b0, 0);
        for (int t = 0; t < 8; t++) begin
            ln = $urandom_range(0, 12);
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ln + 1) : 0;
            run_burst(8'($urandom), ln, ab, 1'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
